// File: rtl/echo_feedback_mixer.sv
// Echo mixer: dry + wet*gain/2^GAIN_W, 2-stage saturating pipeline, ramped gain.
// Optional saturation counter enabled by `define ECHO_MIX_CLIPCNT_EN.
module echo_feedback_mixer #(
    parameter int DATA_W    = 8,
    parameter int GAIN_W    = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dry_in,
    input  logic [DATA_W-1:0] wet_in,
    input  logic              sample_valid,
    input  logic [GAIN_W-1:0] gain_target,
    input  logic              gain_load,
`ifdef ECHO_MIX_CLIPCNT_EN
    input  logic              clip_clr,
    output logic [7:0]        clip_count,
`endif
    output logic [DATA_W-1:0] mix_out,
    output logic              mix_valid,
    output logic              clip,
    output logic [GAIN_W-1:0] gain_now,
    output logic              ramping
);

    localparam int P_W = DATA_W + GAIN_W + 1;
    localparam int S_W = DATA_W + 1;

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

    state_t state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] dry_q, dry_d;
    logic [P_W-1:0] prod_q, prod_d;
    logic v1_q, v1_d;
    logic [DATA_W-1:0] mix_q, mix_d;
    logic clip_q, clip_d;
    logic mixv_q, mixv_d;

    logic [P_W-1:0] wet_x, gain_x;
    logic [S_W-1:0] scaled, sum;
    logic sat_hi, sat_lo;
    logic [GAIN_W:0] gain_up, gain_dn_diff, step_w;
    logic prod_lsb_unused;

    // Stage 1: product of signed wet sample and zero-extended gain
    always_comb begin
        wet_x  = {{(GAIN_W+1){wet_in[DATA_W-1]}}, wet_in};
        gain_x = {{(DATA_W+1){1'b0}}, gain_q};
        v1_d   = sample_valid;
        dry_d  = dry_q;
        prod_d = prod_q;
        if (sample_valid) begin
            dry_d  = dry_in;
            prod_d = wet_x * gain_x;
        end
    end

    // Stage 2: the upper product bits are the floor of prod >>> GAIN_W
    assign prod_lsb_unused = ^prod_q[GAIN_W-1:0];

    always_comb begin
        scaled = prod_q[GAIN_W +: S_W];
        sum    = {dry_q[DATA_W-1], dry_q} + scaled;
        sat_hi = !sum[S_W-1] && sum[S_W-2];
        sat_lo = sum[S_W-1] && !sum[S_W-2];
        mixv_d = v1_q;
        mix_d  = mix_q;
        clip_d = clip_q;
        if (v1_q) begin
            clip_d = sat_hi || sat_lo;
            if (sat_hi)
                mix_d = {1'b0, {(DATA_W-1){1'b1}}};
            else if (sat_lo)
                mix_d = {1'b1, {(DATA_W-1){1'b0}}};
            else
                mix_d = sum[DATA_W-1:0];
        end
    end

    // Gain ramp: steps only on accepted samples, toward the registered target
    always_comb begin
        step_w       = (GAIN_W+1)'(RAMP_STEP);
        gain_up      = {1'b0, gain_q} + step_w;
        gain_dn_diff = {1'b0, gain_q} - {1'b0, target_q};
        state_d      = state_q;
        gain_d       = gain_q;
        target_d     = target_q;
        if (gain_load)
            target_d = gain_target;
        if (sample_valid) begin
            unique case (state_q)
                RAMP_UP: begin
                    if (target_q > gain_q)
                        gain_d = (gain_up > {1'b0, target_q}) ?
                                 target_q : gain_up[GAIN_W-1:0];
                end
                RAMP_DOWN: begin
                    if (target_q < gain_q)
                        gain_d = (gain_dn_diff > step_w) ?
                                 gain_q - step_w[GAIN_W-1:0] : target_q;
                end
                default: ;
            endcase
        end
        if (target_q > gain_d)
            state_d = RAMP_UP;
        else if (target_q < gain_d)
            state_d = RAMP_DOWN;
        else
            state_d = IDLE;
        if (gain_load && gain_target == gain_d)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gain_q   <= '0;
            target_q <= '0;
            dry_q    <= '0;
            prod_q   <= '0;
            v1_q     <= 1'b0;
            mix_q    <= '0;
            clip_q   <= 1'b0;
            mixv_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            target_q <= target_d;
            dry_q    <= dry_d;
            prod_q   <= prod_d;
            v1_q     <= v1_d;
            mix_q    <= mix_d;
            clip_q   <= clip_d;
            mixv_q   <= mixv_d;
        end
    end

`ifdef ECHO_MIX_CLIPCNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clip_clr)
            cnt_d = '0;
        else if (mixv_q && clip_q && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign clip_count = cnt_q;
`endif

    assign mix_out   = mix_q;
    assign mix_valid = mixv_q;
    assign clip      = clip_q;
    assign gain_now  = gain_q;
    assign ramping   = (state_q != IDLE);

endmodule

// File: tb/tb_echo_feedback_mixer.sv
// Directed bench for echo_feedback_mixer: mixing, saturation, gain ramp, reset.
// Clip counter checks run when ECHO_MIX_CLIPCNT_EN is defined.
module tb_echo_feedback_mixer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dry_in = '0;
    logic [7:0] wet_in = '0;
    logic       sample_valid = 1'b0;
    logic [3:0] gain_target = '0;
    logic       gain_load = 1'b0;
    logic [7:0] mix_out;
    logic       mix_valid;
    logic       clip;
    logic [3:0] gain_now;
    logic       ramping;
`ifdef ECHO_MIX_CLIPCNT_EN
    logic       clip_clr = 1'b0;
    logic [7:0] clip_count;
`endif

    int n_chk = 0;
    int n_fail = 0;

    echo_feedback_mixer #(.DATA_W(8), .GAIN_W(4), .RAMP_STEP(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .dry_in       (dry_in),
        .wet_in       (wet_in),
        .sample_valid (sample_valid),
        .gain_target  (gain_target),
        .gain_load    (gain_load),
`ifdef ECHO_MIX_CLIPCNT_EN
        .clip_clr     (clip_clr),
        .clip_count   (clip_count),
`endif
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .clip         (clip),
        .gain_now     (gain_now),
        .ramping      (ramping)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_gain(input int g);
        gain_target = 4'(g);
        gain_load = 1'b1;
        step();
        gain_load = 1'b0;
    endtask

    task automatic settle(input int g);
        load_gain(g);
        dry_in = '0;
        wet_in = '0;
        for (int i = 0; i < 40; i++) begin
            if (gain_now == 4'(g) && !ramping)
                break;
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
        end
        check("settle_gain", gain_now, g);
        step();
        step();
    endtask

    task automatic mix1(input string tag, input int d, input int w,
                        input int exp, input int exp_clip);
        dry_in = 8'(d);
        wet_in = 8'(w);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        check({tag, "_valid"}, mix_valid, 1);
        check(tag, $signed(mix_out), exp);
        check({tag, "_clip"}, clip, exp_clip);
    endtask

    initial begin
        #3 rst = 1'b1;
        #1;
        check("rst_mix_out", mix_out, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_clip", clip, 0);
        check("rst_gain", gain_now, 0);
        check("rst_ramping", ramping, 0);
        step();
        rst = 1'b0;

        settle(4);
        mix1("basic", 10, 32, 18, 0);

        dry_in = 8'd1; wet_in = 8'd16; sample_valid = 1'b1;
        step();
        dry_in = 8'd2; wet_in = 8'd32;
        step();
        check("b2b_a_v", mix_valid, 1);
        check("b2b_a", $signed(mix_out), 5);
        dry_in = 8'd3; wet_in = 8'hF0;
        step();
        check("b2b_b_v", mix_valid, 1);
        check("b2b_b", $signed(mix_out), 10);
        sample_valid = 1'b0;
        step();
        check("b2b_c_v", mix_valid, 1);
        check("b2b_c", $signed(mix_out), -1);
        step();
        check("idle_valid", mix_valid, 0);
        check("idle_hold", $signed(mix_out), -1);

        settle(8);
        mix1("pos_sat", 100, 100, 127, 1);
        settle(15);
        mix1("neg_sat", -100, -100, -128, 1);
        settle(1);
        mix1("floor", 0, -1, -1, 0);

        settle(0);
        load_gain(12);
        step();
        check("ramp_start", ramping, 1);
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                repeat (3) step();
                check("stall_gain", gain_now, 6);
            end
            check("ramp_gain", gain_now, i);
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
        end
        check("ramp_end_gain", gain_now, 12);
        check("ramp_end_idle", ramping, 0);
        step();
        step();

        settle(0);
        load_gain(12);
        step();
        repeat (7) begin
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
        end
        check("mid_gain7", gain_now, 7);
        load_gain(5);
        step();
        check("retarget_ramping", ramping, 1);
        check("retarget_hold", gain_now, 7);
        sample_valid = 1'b1;
        step();
        check("down_6", gain_now, 6);
        step();
        sample_valid = 1'b0;
        check("down_5", gain_now, 5);
        check("down_idle", ramping, 0);
        step();
        step();

        settle(4);
        dry_in = 8'd0; wet_in = 8'd16;
        gain_target = 4'd8; gain_load = 1'b1; sample_valid = 1'b1;
        step();
        gain_load = 1'b0; sample_valid = 1'b0;
        check("same_edge_gain", gain_now, 4);
        step();
        check("same_edge_mix", $signed(mix_out), 4);

        settle(0);
        load_gain(6);
        step();
        repeat (2) begin
            sample_valid = 1'b1;
            step();
            sample_valid = 1'b0;
        end
        check("eq_pre_ramping", ramping, 1);
        load_gain(2);
        check("eq_load_idle", ramping, 0);
        check("eq_load_gain", gain_now, 2);

        settle(8);
        dry_in = 8'd100; wet_in = 8'd100; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        check("pre_rst_valid", mix_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", mix_valid, 0);
        check("mid_rst_out", mix_out, 0);
        check("mid_rst_gain", gain_now, 0);
        check("mid_rst_ramping", ramping, 0);
        step();
        rst = 1'b0;
        step();
        step();
        check("post_rst_valid", mix_valid, 0);
        mix1("post_rst_first", 10, 32, 10, 0);

`ifdef ECHO_MIX_CLIPCNT_EN
        check("cnt_reset", clip_count, 0);
        settle(8);
        dry_in = 8'd100; wet_in = 8'd100; sample_valid = 1'b1;
        repeat (300) step();
        sample_valid = 1'b0;
        repeat (3) step();
        check("cnt_sat", clip_count, 255);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        step();
        check("cnt_clr_clip", clip, 1);
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        check("cnt_clr", clip_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_feedback_mixer.md
Name: echo_feedback_mixer

Overview:
- Downstream consumer of the delay-line outputs. Mixes the current dry sample with the selected delayed (wet) sample to produce an echo.
- Output is dry + wet*gain/2^GAIN_W, computed in a 2-stage pipeline with saturation.
- A gain-ramp FSM slews the applied gain one step per accepted sample toward a loaded target, so gain changes make no zipper noise.
- Sits between the delay-line tap mux and the uo_out pins.

Parameters:
- DATA_W, 8, sample width; two's-complement signed.
- GAIN_W, 4, gain width; gain g means g/2^GAIN_W (unsigned, max (2^GAIN_W-1)/2^GAIN_W).
- RAMP_STEP, 1, gain change applied per accepted sample while ramping; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dry_in  in  DATA_W  current input sample (signed).
- wet_in  in  DATA_W  delayed sample from the delay line (signed).
- sample_valid  in  1  dry_in/wet_in valid this cycle; accepted every cycle it is high.
- gain_target  in  GAIN_W  new target gain.
- gain_load  in  1  1-cycle strobe; captures gain_target.
- mix_out  out  DATA_W  mixed, saturated sample.
- mix_valid  out  1  mix_out valid.
- clip  out  1  mix_out was saturated; valid with mix_valid.
- gain_now  out  GAIN_W  currently applied gain.
- ramping  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - mix_out=0, mix_valid=0, clip=0, gain_now=0, target=0, ramping=0, FSM=IDLE.
  - Pipeline valid bits are cleared; in-flight samples are dropped.
  - The first sample can be accepted on the first rising edge after rst deasserts.
- Stage 1 (edge N, sample_valid=1):
  - Register dry_in.
  - Register prod = wet_in * gain_now as a signed (DATA_W+GAIN_W+1)-bit product; gain is zero-extended.
  - gain_now sampled is the value before any ramp update on that same edge.
- Stage 2 (edge N+1):
  - scaled = prod >>> GAIN_W (arithmetic shift, floor rounding).
  - sum = dry + scaled, computed in DATA_W+1 bits.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; clip=1 if saturated.
  - Register mix_out and clip; mix_valid=1.
- Latency: mix_valid is high in the cycle after edge N+1, i.e. 2 cycles after acceptance. Throughput is 1 sample/clock.
- When no sample is accepted, mix_valid=0 and mix_out/clip hold their last values.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN.
  - On gain_load, target <= gain_target. The next state is evaluated from the new target on the following edges.
  - IDLE: if target>gain_now -> RAMP_UP; if target<gain_now -> RAMP_DOWN.
  - RAMP_UP: on each accepted sample, gain_now <= min(gain_now+RAMP_STEP, target). When gain_now==target -> IDLE. If target drops below gain_now -> RAMP_DOWN.
  - RAMP_DOWN: mirror of RAMP_UP using max(gain_now-RAMP_STEP, target); no underflow below target or 0.
  - gain_now moves only on edges with sample_valid=1; with no samples the ramp stalls.
  - gain_load and sample_valid on the same edge: the sample uses the old gain_now. The ramp step on that edge uses the old target; the new target applies from the next edge.
  - gain_load with gain_target==gain_now -> IDLE immediately. Re-loading during a ramp retargets without resetting gain_now.
- ramping = (state != IDLE).

Optional Feature:
- Macro ECHO_MIX_CLIPCNT_EN.
- Defined:
  - Adds input clip_clr (1 bit) and output clip_count (8 bits).
  - clip_count increments on every mix_valid with clip=1 and saturates at 255.
  - clip_clr is a synchronous clear to 0 that takes priority over increment.
  - Async rst clears clip_count to 0.
- Undefined: the ports and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-stream: assert rst while mix_valid=1 -> mix_out=0, mix_valid=0, gain_now=0, ramping=0 immediately (async); no stale output after release.
- Basic mix: gain loaded and settled at 4; dry=10, wet=32 -> mix_out=18, clip=0, 2 cycles after acceptance. Back-to-back samples give one output per clock.
- Positive saturation: gain 8; dry=100, wet=100 -> scaled=50, mix_out=127, clip=1.
- Negative saturation with floor: gain 15; dry=-100, wet=-100 -> scaled=-94, mix_out=-128, clip=1. Also dry=0, wet=-1, gain=1 -> mix_out=-1.
- Ramp:
  - From gain 0, load target 12 -> successive samples use gain 0,1,...,11; ramping falls after the 12th sample, gain_now=12.
  - Load 5 mid-ramp at gain 7 -> RAMP_DOWN, gain steps 6,5, then IDLE.
  - Idle gaps stall gain_now.
- Clip counter (with ECHO_MIX_CLIPCNT_EN): 300 clipping samples -> clip_count=255. clip_clr together with a clipping sample -> 0.
